// File: rtl/debug_display_scanner.sv
// debug_display_scanner: picks one of CHANNELS debug words, either by manual select or by timed scan,
// and renders it in hex or decimal onto active-low seven-segment digits.
module debug_display_scanner #(
    parameter int CHANNELS = 16,
    parameter int WIDTH    = 16,
    parameter int DIGITS   = 6,
    parameter int SCAN_DIV = 90000000,
    parameter int SEL_W    = $clog2(CHANNELS)
) (
    input  logic                      main_clk,
    input  logic                      reset_n,
    input  logic [CHANNELS*WIDTH-1:0] channel_data,
    input  logic [SEL_W-1:0]          sel,
    input  logic                      auto_scan,
    input  logic                      mode,
    input  logic                      freeze,
    output logic [DIGITS*8-1:0]       hex_out,
    output logic [SEL_W-1:0]          shown_channel,
    output logic                      busy
);
    localparam int HEX_DIGITS = (WIDTH + 3) / 4;
    localparam int HEXPAD_N   = (HEX_DIGITS > DIGITS) ? HEX_DIGITS : DIGITS;
    // Enough BCD nibbles for the whole input range, and never fewer than DIGITS+1 so overflow is visible.
    localparam int DEC_NEED   = (WIDTH * 30103) / 100000 + 2;
    localparam int BCD_N      = (DEC_NEED > DIGITS + 1) ? DEC_NEED : DIGITS + 1;
    localparam int BCD_W      = BCD_N * 4;
    localparam int CNT_W      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int ITER_W     = $clog2(WIDTH + 1);
    localparam logic [SEL_W-1:0]  LAST_CH  = SEL_W'(CHANNELS - 1);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(SCAN_DIV - 1);
    localparam logic [ITER_W-1:0] LAST_IT  = ITER_W'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, CONVERT, UPDATE} state_t;

    state_t                r_state;
    logic [CNT_W-1:0]      r_scanCnt;
    logic [SEL_W-1:0]      r_scanIdx;
    logic [WIDTH-1:0]      r_data;
    logic                  r_mode;
    logic                  r_auto;
    logic [SEL_W-1:0]      r_chan;
    logic [BCD_W-1:0]      r_bcd;
    logic [ITER_W-1:0]     r_iter;
    logic [DIGITS*8-1:0]   r_hexOut;
    logic [SEL_W-1:0]      r_shown;

    logic [SEL_W-1:0]      w_selClamp;
    logic [WIDTH-1:0]      w_chanWord;
    logic [BCD_W-1:0]      w_bcdAdj;
    logic [HEXPAD_N*4-1:0] w_hexPad;
    logic                  w_overflow;
    logic                  w_leadZero;
    logic [DIGITS*8-1:0]   w_render;

    function automatic logic [7:0] segOf(input logic [3:0] v);
        case (v)
            4'h0: segOf = 8'hC0;
            4'h1: segOf = 8'hF9;
            4'h2: segOf = 8'hA4;
            4'h3: segOf = 8'hB0;
            4'h4: segOf = 8'h99;
            4'h5: segOf = 8'h92;
            4'h6: segOf = 8'h82;
            4'h7: segOf = 8'hF8;
            4'h8: segOf = 8'h80;
            4'h9: segOf = 8'h90;
            4'hA: segOf = 8'h88;
            4'hB: segOf = 8'h83;
            4'hC: segOf = 8'hC6;
            4'hD: segOf = 8'hA1;
            4'hE: segOf = 8'h86;
            default: segOf = 8'h8E;
        endcase
    endfunction

    assign w_selClamp = (int'(sel) >= CHANNELS) ? LAST_CH : sel;
    assign w_chanWord = channel_data[int'(r_scanIdx) * WIDTH +: WIDTH];

    // Manual mode tracks sel continuously; auto mode rotates channels every SCAN_DIV cycles unless frozen.
    always_ff @(posedge main_clk) begin
        if (!reset_n) begin
            r_scanCnt <= '0;
            r_scanIdx <= '0;
        end else if (!auto_scan) begin
            r_scanCnt <= '0;
            r_scanIdx <= w_selClamp;
        end else if (!freeze) begin
            if (r_scanCnt == LAST_CNT) begin
                r_scanCnt <= '0;
                r_scanIdx <= (r_scanIdx == LAST_CH) ? '0 : r_scanIdx + 1'b1;
            end else begin
                r_scanCnt <= r_scanCnt + 1'b1;
            end
        end
    end

    always_comb begin
        w_bcdAdj = r_bcd;
        for (int n = 0; n < BCD_N; n++) begin
            if (r_bcd[n*4 +: 4] >= 4'd5) begin
                w_bcdAdj[n*4 +: 4] = r_bcd[n*4 +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge main_clk) begin
        if (!reset_n) begin
            r_state  <= IDLE;
            r_data   <= '0;
            r_mode   <= 1'b0;
            r_auto   <= 1'b0;
            r_chan   <= '0;
            r_bcd    <= '0;
            r_iter   <= '0;
            r_hexOut <= '1;
            r_shown  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (!freeze) begin
                        r_data  <= w_chanWord;
                        r_mode  <= mode;
                        r_auto  <= auto_scan;
                        r_chan  <= r_scanIdx;
                        r_bcd   <= '0;
                        r_iter  <= '0;
                        r_state <= CONVERT;
                    end
                end
                CONVERT: begin
                    if (!r_mode) begin
                        r_state <= UPDATE;
                    end else begin
                        r_bcd  <= {w_bcdAdj[BCD_W-2:0], r_data[WIDTH-1]};
                        r_data <= {r_data[WIDTH-2:0], 1'b0};
                        r_iter <= r_iter + 1'b1;
                        if (r_iter == LAST_IT) begin
                            r_state <= UPDATE;
                        end
                    end
                end
                UPDATE: begin
                    r_hexOut <= w_render;
                    r_shown  <= r_chan;
                    r_state  <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Decimal digits stay blank until the first nonzero nibble from the top; digit 0 always shows.
    always_comb begin
        w_hexPad               = '0;
        w_hexPad[WIDTH-1:0]    = r_data;
        w_overflow             = 1'b0;
        w_leadZero             = 1'b1;
        w_render               = '1;
        for (int n = DIGITS; n < BCD_N; n++) begin
            if (r_bcd[n*4 +: 4] != 4'd0) begin
                w_overflow = 1'b1;
            end
        end
        for (int d = DIGITS - 1; d >= 0; d--) begin
            if (!r_mode) begin
                if (d < HEX_DIGITS) begin
                    w_render[d*8 +: 8] = segOf(w_hexPad[d*4 +: 4]);
                end
            end else if (w_overflow) begin
                w_render[d*8 +: 8] = 8'hBF;
            end else begin
                if (r_bcd[d*4 +: 4] != 4'd0 || d == 0) begin
                    w_leadZero = 1'b0;
                end
                if (!w_leadZero) begin
                    w_render[d*8 +: 8] = segOf(r_bcd[d*4 +: 4]);
                end
            end
        end
        w_render[DIGITS*8-1] = ~r_auto;
    end

    assign hex_out       = r_hexOut;
    assign shown_channel = r_shown;
    assign busy          = (r_state != IDLE);

endmodule

// File: tb/tb_debug_display_scanner.sv
// tb_debug_display_scanner: directed vectors on three scanner configurations; expectations are queued
// when a capture is launched and popped by a monitor whenever a display update completes.
`timescale 1ns/1ps
module tb_debug_display_scanner;

    typedef struct packed {
        logic [47:0] hex;
        int          chan;
        int          lat;
        int          cap;
    } expect_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cycle    = 0;
    expect_t sbQ [3][$];

    logic       rstN     [3];
    logic       freezeIn [3];
    logic       modeIn   [3];
    logic       autoIn   [3];
    logic [3:0] selIn    [3];

    logic [16*16-1:0] dataA;
    logic [12*20-1:0] dataB;
    logic [4*16-1:0]  dataD;
    logic [47:0]      hexA, hexB, hexD;
    logic [3:0]       shownA, shownB;
    logic [1:0]       shownD;
    logic             busyA, busyB, busyD;

    logic [47:0] hexMon   [3];
    logic [3:0]  shownMon [3];
    logic        busyMon  [3];

    assign hexMon[0]   = hexA;
    assign hexMon[1]   = hexB;
    assign hexMon[2]   = hexD;
    assign shownMon[0] = shownA;
    assign shownMon[1] = shownB;
    assign shownMon[2] = {2'b00, shownD};
    assign busyMon[0]  = busyA;
    assign busyMon[1]  = busyB;
    assign busyMon[2]  = busyD;

    debug_display_scanner #(.CHANNELS(16), .WIDTH(16), .DIGITS(6), .SCAN_DIV(90000000)) dutA (
        .main_clk(clk), .reset_n(rstN[0]), .channel_data(dataA), .sel(selIn[0]),
        .auto_scan(autoIn[0]), .mode(modeIn[0]), .freeze(freezeIn[0]),
        .hex_out(hexA), .shown_channel(shownA), .busy(busyA));

    debug_display_scanner #(.CHANNELS(12), .WIDTH(20), .DIGITS(6), .SCAN_DIV(8)) dutB (
        .main_clk(clk), .reset_n(rstN[1]), .channel_data(dataB), .sel(selIn[1]),
        .auto_scan(autoIn[1]), .mode(modeIn[1]), .freeze(freezeIn[1]),
        .hex_out(hexB), .shown_channel(shownB), .busy(busyB));

    debug_display_scanner #(.CHANNELS(4), .WIDTH(16), .DIGITS(6), .SCAN_DIV(4)) dutD (
        .main_clk(clk), .reset_n(rstN[2]), .channel_data(dataD), .sel(selIn[2][1:0]),
        .auto_scan(autoIn[2]), .mode(modeIn[2]), .freeze(freezeIn[2]),
        .hex_out(hexD), .shown_channel(shownD), .busy(busyD));

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic checkReset(input int k);
        checkOutput($sformatf("dut%0d_reset_hex", k), 64'(hexMon[k]), 64'(48'hFFFF_FFFF_FFFF));
        checkOutput($sformatf("dut%0d_reset_chan", k), 64'(shownMon[k]), 64'd0);
        checkOutput($sformatf("dut%0d_reset_busy", k), 64'(busyMon[k]), 64'd0);
    endtask

    // Queue the expected result, open freeze for one capture, then close it after 'hold' cycles (0 = caller closes).
    task automatic applyStimulus(input int k, input logic [47:0] expHex, input int expChan,
                                 input int expLat, input int hold);
        expect_t e;
        @(negedge clk);
        e.hex  = expHex;
        e.chan = expChan;
        e.lat  = expLat;
        e.cap  = cycle + 1;
        sbQ[k].push_back(e);
        freezeIn[k] = 1'b0;
        if (hold > 0) begin
            repeat (hold) @(negedge clk);
            freezeIn[k] = 1'b1;
        end
    endtask

    task automatic waitDrain(input int k, input int budget);
        int n = 0;
        while (sbQ[k].size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (sbQ[k].size() != 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL dut%0d_drain_timeout: %0d updates pending, expected 0", k, sbQ[k].size());
            sbQ[k].delete();
        end
    endtask

    // An update is a busy 1->0 transition on an edge where reset was not asserted.
    initial begin : monitor
        logic    prevBusy [3];
        int      busyRun  [3];
        expect_t e;
        for (int k = 0; k < 3; k++) begin
            prevBusy[k] = 1'b0;
            busyRun[k]  = 0;
        end
        forever begin
            @(posedge clk);
            #1;
            cycle++;
            for (int k = 0; k < 3; k++) begin
                if (prevBusy[k] && !busyMon[k] && rstN[k]) begin
                    if (sbQ[k].size() == 0) begin
                        checks++;
                        failures++;
                        $display("[TB] FAIL dut%0d_unexpected_update: got hex %h, expected no update", k, hexMon[k]);
                    end else begin
                        e = sbQ[k].pop_front();
                        checkOutput($sformatf("dut%0d_hex", k), 64'(hexMon[k]), 64'(e.hex));
                        checkOutput($sformatf("dut%0d_chan", k), 64'(shownMon[k]), 64'(e.chan));
                        checkOutput($sformatf("dut%0d_latency", k), 64'(cycle - e.cap + 1), 64'(e.lat));
                        checkOutput($sformatf("dut%0d_busy_cycles", k), 64'(busyRun[k]), 64'(e.lat - 1));
                    end
                end
                busyRun[k]  = busyMon[k] ? busyRun[k] + 1 : 0;
                prevBusy[k] = busyMon[k];
            end
        end
    end

    initial begin : stimulus
        logic [7:0] dSeg  [7];
        int         dChan [7];
        int         base;
        for (int k = 0; k < 3; k++) begin
            rstN[k]     = 1'b0;
            freezeIn[k] = 1'b1;
            modeIn[k]   = 1'b0;
            autoIn[k]   = 1'b0;
            selIn[k]    = 4'd0;
        end
        dataA = '0;
        dataB = '0;
        dataD = '0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) checkReset(k);
        rstN[0] = 1'b1;
        rstN[1] = 1'b1;

        // Manual decimal, hex, max value, zero and hex zero on the default configuration.
        modeIn[0] = 1'b1; selIn[0] = 4'd3; dataA[3*16 +: 16] = 16'd12345;
        applyStimulus(0, 48'hFF_F9_A4_B0_99_92, 3, 18, 2);
        waitDrain(0, 40);
        modeIn[0] = 1'b0; selIn[0] = 4'd0; dataA[0 +: 16] = 16'hBEEF;
        applyStimulus(0, 48'hFF_FF_83_86_86_8E, 0, 3, 1);
        waitDrain(0, 20);
        modeIn[0] = 1'b1; selIn[0] = 4'd7; dataA[7*16 +: 16] = 16'hFFFF;
        applyStimulus(0, 48'hFF_82_92_92_B0_92, 7, 18, 2);
        waitDrain(0, 40);
        modeIn[0] = 1'b1; selIn[0] = 4'd5;
        applyStimulus(0, 48'hFF_FF_FF_FF_FF_C0, 5, 18, 2);
        waitDrain(0, 40);
        modeIn[0] = 1'b0; selIn[0] = 4'd15;
        applyStimulus(0, 48'hFF_FF_C0_C0_C0_C0, 15, 3, 1);
        waitDrain(0, 20);

        // Inputs change mid-conversion and freeze rises in CONVERT; the captured value must still land.
        modeIn[0] = 1'b1; selIn[0] = 4'd1; dataA[1*16 +: 16] = 16'd100;
        applyStimulus(0, 48'hFF_FF_FF_F9_C0_C0, 1, 18, 0);
        repeat (2) @(negedge clk);
        dataA[1*16 +: 16] = 16'd999;
        modeIn[0] = 1'b0;
        selIn[0]  = 4'd2;
        repeat (3) @(negedge clk);
        freezeIn[0] = 1'b1;
        waitDrain(0, 40);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            dataA[1*16 +: 16] = 16'(i * 7 + 1);
            checkOutput("freeze_hold_hex", 64'(hexA), 64'(48'hFF_FF_FF_F9_C0_C0));
            checkOutput("freeze_hold_busy", 64'(busyA), 64'd0);
        end
        checkOutput("freeze_hold_chan", 64'(shownA), 64'd1);

        // Reset pulse in the middle of a decimal conversion.
        modeIn[0] = 1'b1; selIn[0] = 4'd3;
        @(negedge clk);
        freezeIn[0] = 1'b0;
        @(negedge clk);
        freezeIn[0] = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("busy_mid_convert", 64'(busyA), 64'd1);
        rstN[0] = 1'b0;
        @(negedge clk);
        checkReset(0);
        rstN[0] = 1'b1;
        repeat (20) @(negedge clk);
        checkReset(0);
        modeIn[0] = 1'b0;
        applyStimulus(0, 48'hFF_FF_B0_C0_B0_90, 3, 3, 1);
        waitDrain(0, 20);

        // Twelve channels of 20 bits: clamp, zero, overflow and largest six-digit value.
        modeIn[1] = 1'b1; selIn[1] = 4'd15;
        applyStimulus(1, 48'hFF_FF_FF_FF_FF_C0, 11, 22, 2);
        waitDrain(1, 40);
        selIn[1] = 4'd0; dataB[0 +: 20] = 20'd1048575;
        applyStimulus(1, 48'hBF_BF_BF_BF_BF_BF, 0, 22, 2);
        waitDrain(1, 40);
        dataB[0 +: 20] = 20'd999999;
        applyStimulus(1, 48'h90_90_90_90_90_90, 0, 22, 2);
        waitDrain(1, 40);
        dataB[0 +: 20] = 20'd1000000;
        applyStimulus(1, 48'hBF_BF_BF_BF_BF_BF, 0, 22, 2);
        waitDrain(1, 40);
        modeIn[1] = 1'b0; selIn[1] = 4'd12; dataB[11*20 +: 20] = 20'hA5C3D;
        applyStimulus(1, 48'hFF_88_92_C6_B0_A1, 11, 3, 1);
        waitDrain(1, 20);

        // Auto-scan: captures every 3 cycles, channel advances every 4, starting from the reset release.
        dSeg  = '{8'hC0, 8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'hB0, 8'hC0};
        dChan = '{0, 0, 1, 2, 3, 3, 0};
        autoIn[2]   = 1'b1;
        modeIn[2]   = 1'b0;
        freezeIn[2] = 1'b0;
        dataD       = {16'd3, 16'd2, 16'd1, 16'd0};
        @(negedge clk);
        base = cycle;
        for (int i = 0; i < 7; i++) begin
            expect_t e;
            e.hex  = {8'h7F, 8'hFF, 8'hC0, 8'hC0, 8'hC0, dSeg[i]};
            e.chan = dChan[i];
            e.lat  = 3;
            e.cap  = base + 1 + 3 * i;
            sbQ[2].push_back(e);
        end
        rstN[2] = 1'b1;
        repeat (20) @(negedge clk);
        freezeIn[2] = 1'b1;
        waitDrain(2, 20);

        repeat (5) @(negedge clk);
        for (int k = 0; k < 3; k++) waitDrain(k, 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
